dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_lane.sv | 42 ++++
 rtl/dmem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and default parameters for the data-memory controller.
// Optional feature macro used by dmem_ctrl: MISALIGN_TRAP_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH_LOG2  = 11;
  localparam int DEF_WAIT_CYCLES = 1;

  // Reserved size code 2'b11 behaves as a full word.
  function automatic int size_bytes(input logic [1:0] sz, input int word_bytes);
    case (sz)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      default: return word_bytes;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational lane unit: big-endian lane mask, store alignment and load extract/extend.
// The offset is expected to be already aligned to the access size.
module dmem_lane
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rword_i,
  output logic [DATA_W-1:0] mask_o,
  output logic [DATA_W-1:0] wword_o,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int NB = DATA_W / 8;

  int                nbytes;
  int                sh;
  logic [DATA_W-1:0] ones;
  logic [DATA_W-1:0] field;
  logic              sign;

  always_comb begin
    nbytes  = size_bytes(size_i, NB);
    // Offset 0 is the most significant byte, so the lane sits sh bits above bit 0.
    sh      = (NB - nbytes - int'(off_i)) * 8;
    ones    = (DATA_W'(1) << (nbytes * 8)) - DATA_W'(1);
    mask_o  = ones << sh;
    wword_o = (wdata_i & ones) << sh;
    field   = (rword_i >> sh) & ones;
    sign    = |(field & (ones ^ (ones >> 1)));
    rdata_o = field;
    if (!unsigned_i && sign) begin
      rdata_o = field | ~ones;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request in flight, WAIT_CYCLES wait states, big-endian lanes.
// Define MISALIGN_TRAP_EN to flag misaligned accesses instead of silently aligning them.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output dmem_state_e       dbg_state
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int AW    = DEPTH_LOG2 + OFF_W;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Handshake: a request transfers on an edge where req_valid && req_ready; a response
  // transfers on an edge where resp_valid && resp_ready. Neither side may drop a
  // pending valid, and the controller holds resp_rdata/resp_err stable while resp_valid.

  dmem_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, uns_q;
  logic [1:0]        size_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, enter_resp, do_write, mis, trap, unused_bits;
  logic              cur_write, cur_uns;
  logic [1:0]        cur_size;
  logic [AW-1:0]     cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DEPTH_LOG2-1:0] idx;
  logic [OFF_W-1:0]  off, off_al;
  logic [DATA_W-1:0] lane_mask, lane_wword, lane_rdata;

  assign accept     = req_valid && (state_q == S_IDLE);
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // With zero wait states the storage access happens on the accept edge itself.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_write = req_write;
      cur_size  = req_size;
      cur_uns   = req_unsigned;
      cur_addr  = req_addr[AW-1:0];
      cur_wdata = req_wdata;
    end else begin
      cur_write = write_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign idx = cur_addr[AW-1:OFF_W];
  assign off = cur_addr[OFF_W-1:0];

  always_comb begin
    case (cur_size)
      SZ_BYTE: begin off_al = off;                 mis = 1'b0;   end
      SZ_HALF: begin off_al = off & ~OFF_W'(1);    mis = off[0]; end
      default: begin off_al = '0;                  mis = |off;   end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap        = mis;
  assign unused_bits = ^req_addr[DATA_W-1:AW];
`else
  assign trap        = 1'b0;
  assign unused_bits = ^{req_addr[DATA_W-1:AW], mis};
`endif

  dmem_lane #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_lane (
    .size_i     (cur_size),
    .unsigned_i (cur_uns),
    .off_i      (off_al),
    .wdata_i    (cur_wdata),
    .rword_i    (mem_q[idx]),
    .mask_o     (lane_mask),
    .wword_o    (lane_wword),
    .rdata_o    (lane_rdata)
  );

  assign do_write = !rst && enter_resp && cur_write && !trap;
  assign rdata_d  = (cur_write || trap) ? '0 : lane_rdata;
  assign err_d    = trap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
    end
  end

  // Storage has no reset: contents survive rst and are undefined until written.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[idx] <= (mem_q[idx] & ~lane_mask) | lane_wword;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (1 and 3 wait states) driven in lockstep, a directed
// vector table, backpressure/reset sequences, and random traffic against a byte-array model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_write, req_unsigned, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready_a, resp_valid_a, resp_err_a, busy_a;
  logic        req_ready_b, resp_valid_b, resp_err_b, busy_b;
  logic [31:0] resp_rdata_a, resp_rdata_b;
  dmem_state_e dbg_a, dbg_b;

  dmem_ctrl #(.DATA_W(32), .DEPTH_LOG2(11), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_a),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .busy(busy_a), .dbg_state(dbg_a)
  );

  dmem_ctrl #(.DATA_W(32), .DEPTH_LOG2(11), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_b),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .busy(busy_b), .dbg_state(dbg_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model: byte-addressed, big-endian ----------------
  logic [7:0] mem_m [8192];

  function automatic void model_txn(input logic wr, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output logic err);
    int         nb, base;
    logic [63:0] v;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(addr % 32'd8192);
    base = base - (base % nb);
    rd   = 32'd0;
    err  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((addr % nb) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    if (wr) begin
      for (int i = 0; i < nb; i++) mem_m[base + i] = 8'(wd >> (8 * (nb - 1 - i)));
    end else begin
      v = 64'd0;
      for (int i = 0; i < nb; i++) v = (v << 8) | 64'(mem_m[base + i]);
      if (!uns && v[8 * nb - 1]) v = v | (~64'd0 << (8 * nb));
      rd = v[31:0];
    end
  endfunction

  // ---------------- driver ----------------
  task automatic run_txn(input string name, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd_a, output logic [31:0] rd_b,
                         output logic er_a, output logic er_b);
    int lat, lat_a, lat_b;
    bit got_a, got_b;
    @(negedge clk);
    check_bit({name, " ready_a"}, req_ready_a, 1'b1);
    check_bit({name, " ready_b"}, req_ready_b, 1'b1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; lat_a = 0; lat_b = 0; got_a = 0; got_b = 0;
    rd_a = 32'hx; rd_b = 32'hx; er_a = 1'bx; er_b = 1'bx;
    while (!(got_a && got_b) && lat <= 20) begin
      if (!got_a && resp_valid_a) begin
        got_a = 1; lat_a = lat; rd_a = resp_rdata_a; er_a = resp_err_a;
      end
      if (!got_b && resp_valid_b) begin
        got_b = 1; lat_b = lat; rd_b = resp_rdata_b; er_b = resp_err_b;
      end
      if (!(got_a && got_b)) begin
        @(posedge clk); #1;
        lat++;
      end
    end
    // Latency counted in edges from (and including) the accepting edge: WAIT_CYCLES+1.
    check({name, " latency_a"}, 32'(lat_a), 32'd2);
    check({name, " latency_b"}, 32'(lat_b), 32'd4);
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [32];
  int   n_vecs = 0;

  function automatic void add_vec(input logic wr, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] exp_rd, input logic exp_err);
    vecs[n_vecs] = '{wr, sz, uns, addr, wd, exp_rd, exp_err};
    n_vecs++;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_a, rd_b, m_rd;
    logic        er_a, er_b, m_er;
    logic        seen_resp;
    logic        t_wr, t_uns;
    logic [1:0]  t_sz;
    logic [31:0] t_addr, t_wd;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_WORD;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;

    add_vec(1, SZ_WORD, 0, 32'h10,        32'h12345678, 32'h0,        0);
    add_vec(0, SZ_WORD, 0, 32'h10,        32'h0,        32'h12345678, 0);
    add_vec(0, SZ_BYTE, 0, 32'h13,        32'h0,        32'h00000078, 0);
    add_vec(1, SZ_BYTE, 0, 32'h10,        32'h00000080, 32'h0,        0);
    add_vec(0, SZ_BYTE, 0, 32'h10,        32'h0,        32'hFFFFFF80, 0);
    add_vec(0, SZ_BYTE, 1, 32'h10,        32'h0,        32'h00000080, 0);
    add_vec(1, SZ_BYTE, 0, 32'h10,        32'h00000012, 32'h0,        0);
    add_vec(1, SZ_HALF, 0, 32'h12,        32'h0000BEEF, 32'h0,        0);
    add_vec(0, SZ_WORD, 0, 32'h10,        32'h0,        32'h1234BEEF, 0);
    add_vec(0, SZ_HALF, 0, 32'h12,        32'h0,        32'hFFFFBEEF, 0);
    add_vec(0, SZ_HALF, 1, 32'h12,        32'h0,        32'h0000BEEF, 0);
    add_vec(0, SZ_BYTE, 0, 32'h11,        32'h0,        32'h00000034, 0);
    add_vec(0, 2'b11,   0, 32'h10,        32'h0,        32'h1234BEEF, 0);
    add_vec(1, SZ_WORD, 0, 32'h20,        32'h11111111, 32'h0,        0);
    add_vec(1, SZ_WORD, 0, 32'h21,        32'hCAFEF00D, 32'h0,        TRAP);
    add_vec(0, SZ_WORD, 0, 32'h20,        32'h0,        TRAP ? 32'h11111111 : 32'hCAFEF00D, 0);
    add_vec(1, SZ_BYTE, 0, 32'h23,        32'hFFFFFF5A, 32'h0,        0);
    add_vec(0, SZ_WORD, 0, 32'h20,        32'h0,        TRAP ? 32'h1111115A : 32'hCAFEF05A, 0);
    add_vec(0, SZ_HALF, 1, 32'h13,        32'h0,        TRAP ? 32'h0 : 32'h0000BEEF, TRAP);
    add_vec(1, SZ_WORD, 0, 32'h2000,      32'hA5A55A5A, 32'h0,        0);
    add_vec(0, SZ_WORD, 0, 32'h0,         32'h0,        32'hA5A55A5A, 0);
    add_vec(0, SZ_WORD, 0, 32'h2010,      32'h0,        32'h1234BEEF, 0);
    add_vec(0, SZ_WORD, 0, 32'hFFFFE010,  32'h0,        32'h1234BEEF, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst req_ready_a", req_ready_a, 1'b1);
    check_bit("rst req_ready_b", req_ready_b, 1'b1);
    check_bit("rst resp_valid_a", resp_valid_a, 1'b0);
    check_bit("rst resp_valid_b", resp_valid_b, 1'b0);
    check_bit("rst busy_a", busy_a, 1'b0);
    check_bit("rst busy_b", busy_b, 1'b0);
    check_bit("rst resp_err_a", resp_err_a, 1'b0);
    check("rst resp_rdata_a", resp_rdata_a, 32'h0);
    check("rst resp_rdata_b", resp_rdata_b, 32'h0);
    check("rst state_a", 32'(dbg_a), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < n_vecs; i++) begin
      model_txn(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, m_rd, m_er);
      run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
              vecs[i].wdata, rd_a, rd_b, er_a, er_b);
      check($sformatf("vec%0d rdata_a", i), rd_a, vecs[i].exp_rd);
      check($sformatf("vec%0d rdata_b", i), rd_b, vecs[i].exp_rd);
      check_bit($sformatf("vec%0d err_a", i), er_a, vecs[i].exp_err);
      check_bit($sformatf("vec%0d err_b", i), er_b, vecs[i].exp_err);
    end

    // Backpressure: response held 5 cycles, then a request offered on the pop edge is ignored
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_bit($sformatf("bp%0d resp_valid_a", i), resp_valid_a, 1'b1);
      check_bit($sformatf("bp%0d resp_valid_b", i), resp_valid_b, 1'b1);
      check($sformatf("bp%0d rdata_a", i), resp_rdata_a, 32'h1234BEEF);
      check($sformatf("bp%0d rdata_b", i), resp_rdata_b, 32'h1234BEEF);
      check_bit($sformatf("bp%0d req_ready_a", i), req_ready_a, 1'b0);
      check_bit($sformatf("bp%0d req_ready_b", i), req_ready_b, 1'b0);
      check_bit($sformatf("bp%0d busy_b", i), busy_b, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    resp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
    req_wdata = 32'hDEADDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_bit("pop resp_valid_a", resp_valid_a, 1'b0);
    check_bit("pop resp_valid_b", resp_valid_b, 1'b0);
    check_bit("pop busy_a", busy_a, 1'b0);
    check_bit("pop busy_b", busy_b, 1'b0);
    run_txn("after_pop", 0, SZ_WORD, 0, 32'h10, 32'h0, rd_a, rd_b, er_a, er_b);
    check("after_pop rdata_a", rd_a, 32'h1234BEEF);
    check("after_pop rdata_b", rd_b, 32'h1234BEEF);

    // Reset one cycle after accepting a store: store is dropped, no response
    model_txn(1, SZ_WORD, 0, 32'h40, 32'h0BADF00D, m_rd, m_er);
    run_txn("pre_rst", 1, SZ_WORD, 0, 32'h40, 32'h0BADF00D, rd_a, rd_b, er_a, er_b);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_addr = 32'h40;
    req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_bit("abort busy_a", busy_a, 1'b1);
    check_bit("abort busy_b", busy_b, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_bit("abort req_ready_a", req_ready_a, 1'b1);
    check_bit("abort req_ready_b", req_ready_b, 1'b1);
    check_bit("abort busy_b", busy_b, 1'b0);
    check_bit("abort resp_valid_b", resp_valid_b, 1'b0);
    check("abort state_b", 32'(dbg_b), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    seen_resp = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen_resp = seen_resp | resp_valid_a | resp_valid_b;
    end
    check_bit("abort no_response", seen_resp, 1'b0);
    run_txn("post_rst", 0, SZ_WORD, 0, 32'h40, 32'h0, rd_a, rd_b, er_a, er_b);
    check("post_rst rdata_a", rd_a, 32'h0BADF00D);
    check("post_rst rdata_b", rd_b, 32'h0BADF00D);

    // Random traffic in a 64-byte window, upper address bits randomized
    for (int w = 0; w < 16; w++) begin
      t_wd = $urandom;
      model_txn(1, SZ_WORD, 0, 32'h100 + 32'(4 * w), t_wd, m_rd, m_er);
      run_txn("init", 1, SZ_WORD, 0, 32'h100 + 32'(4 * w), t_wd, rd_a, rd_b, er_a, er_b);
    end
    for (int t = 0; t < 250; t++) begin
      t_wr   = 1'($urandom_range(0, 1));
      t_sz   = 2'($urandom_range(0, 3));
      t_uns  = 1'($urandom_range(0, 1));
      t_addr = ($urandom & 32'hFFFFE000) | (32'h100 + 32'($urandom_range(0, 63)));
      t_wd   = $urandom;
      model_txn(t_wr, t_sz, t_uns, t_addr, t_wd, m_rd, m_er);
      run_txn($sformatf("rnd%0d", t), t_wr, t_sz, t_uns, t_addr, t_wd, rd_a, rd_b, er_a, er_b);
      check($sformatf("rnd%0d rdata_a", t), rd_a, m_rd);
      check($sformatf("rnd%0d rdata_b", t), rd_b, m_rd);
      check_bit($sformatf("rnd%0d err_a", t), er_a, m_er);
      check_bit($sformatf("rnd%0d err_b", t), er_b, m_er);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
